// File: rtl/sprite_layer_if.sv
// VGA stream bundle passed between pipeline stages: timing counters,
// sync/blank strobes and one 12-bit pixel.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  // Consumer (slave) side.
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  // Producer (master) side.
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/sprite_layer.sv
// N-channel sprite overlay: per-channel frame-latched position, mirroring,
// colour-key transparency, fixed-priority compositing and per-frame
// collision flags against channel 0. Fixed 3-cycle in->out latency.

// One sprite channel: shadow registers, hit test, ROM address, hit delay.
module sprite_lane #(
  parameter int SPR_W = 32,
  parameter int SPR_H = 32,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_latch,
  input  logic          i_active,
  input  logic [10:0]   i_xpos,
  input  logic [10:0]   i_ypos,
  input  logic          i_en,
  input  logic          i_mirror,
  input  logic [10:0]   i_hcount,
  input  logic [10:0]   i_vcount,
  output logic [AW-1:0] o_addr,
  output logic          o_hit
);
  localparam int CW = $clog2(SPR_W);
  localparam int RW = AW - CW;

  logic [10:0]   r_x, r_y;
  logic          r_en, r_mirror;
  logic          r_hit1, r_hit2;
  logic [AW-1:0] r_addr;

  logic [11:0]   w_h, w_v, w_x, w_y;
  logic          w_hit;
  logic [CW-1:0] w_dx, w_col;
  logic [RW-1:0] w_dy;

  // Shadow copy of the sprite controls, refreshed only at vblank start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_en     <= 1'b0;
      r_mirror <= 1'b0;
    end else if (i_latch) begin
      r_x      <= i_xpos;
      r_y      <= i_ypos;
      r_en     <= i_en;
      r_mirror <= i_mirror;
    end
  end

  // 12-bit compares so x+SPR_W past 2047 clips instead of wrapping.
  assign w_h   = {1'b0, i_hcount};
  assign w_v   = {1'b0, i_vcount};
  assign w_x   = {1'b0, r_x};
  assign w_y   = {1'b0, r_y};
  assign w_hit = r_en & i_active &
                 (w_h >= w_x) & (w_h < w_x + 12'(SPR_W)) &
                 (w_v >= w_y) & (w_v < w_y + 12'(SPR_H));

  // Only the low bits of the offsets matter once the hit test passed.
  assign w_dx  = i_hcount[CW-1:0] - r_x[CW-1:0];
  assign w_dy  = i_vcount[RW-1:0] - r_y[RW-1:0];
  assign w_col = r_mirror ? ~w_dx : w_dx;

  // Stage 1 address/hit, stage 2 hit delay to line up with ROM data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_hit1 <= 1'b0;
      r_hit2 <= 1'b0;
    end else begin
      r_addr <= w_hit ? {w_dy, w_col} : '0;
      r_hit1 <= w_hit;
      r_hit2 <= r_hit1;
    end
  end

  assign o_addr = r_addr;
  assign o_hit  = r_hit2;
endmodule

module sprite_layer #(
  parameter int          N_SPR  = 4,
  parameter int          SPR_W  = 32,
  parameter int          SPR_H  = 32,
  parameter logic [11:0] TRANSP = 12'hF0F,
  parameter int          AW     = $clog2(SPR_W*SPR_H)
) (
  input  logic                clk,
  input  logic                rst,
  vga_if.in                   in,
  vga_if.out                  out,
  input  logic [N_SPR*11-1:0] xpos,
  input  logic [N_SPR*11-1:0] ypos,
  input  logic [N_SPR-1:0]    spr_en,
  input  logic [N_SPR-1:0]    mirror,
  output logic [N_SPR*AW-1:0] rom_addr,
  input  logic [N_SPR*12-1:0] rom_data,
  output logic [N_SPR-1:0]    collide
);
  // {hcount, vcount, hsync, vsync, hblnk, vblnk, rgb}
  localparam int VW = 38;

  logic [VW-1:0]    w_in_vec, r_p1, r_p2, r_p3;
  logic             r_vblnk_d;
  logic             w_latch, w_active;
  logic [N_SPR-1:0] w_hit2, w_opaque, w_set;
  logic [N_SPR-1:0] r_acc, r_collide;
  logic [11:0]      w_rgb;

  assign w_in_vec = {in.hcount, in.vcount, in.hsync, in.vsync,
                     in.hblnk, in.vblnk, in.rgb};
  assign w_latch  = in.vblnk & ~r_vblnk_d;
  assign w_active = ~in.hblnk & ~in.vblnk;

  genvar gi;
  generate
    for (gi = 0; gi < N_SPR; gi++) begin : g_lane
      sprite_lane #(.SPR_W(SPR_W), .SPR_H(SPR_H), .AW(AW)) u_lane (
        .clk      (clk),
        .rst      (rst),
        .i_latch  (w_latch),
        .i_active (w_active),
        .i_xpos   (xpos[gi*11 +: 11]),
        .i_ypos   (ypos[gi*11 +: 11]),
        .i_en     (spr_en[gi]),
        .i_mirror (mirror[gi]),
        .i_hcount (in.hcount),
        .i_vcount (in.vcount),
        .o_addr   (rom_addr[gi*AW +: AW]),
        .o_hit    (w_hit2[gi])
      );
      assign w_opaque[gi] = w_hit2[gi] & (rom_data[gi*12 +: 12] != TRANSP);
      // Channel 0 cannot collide with itself.
      assign w_set[gi]    = (gi == 0) ? 1'b0 : (w_opaque[0] & w_opaque[gi]);
    end
  endgenerate

  // Lowest-index opaque channel wins; otherwise the delayed input pixel.
  always_comb begin
    w_rgb = r_p2[11:0];
    for (int i = N_SPR-1; i >= 0; i--)
      if (w_opaque[i]) w_rgb = rom_data[i*12 +: 12];
  end

  // Three-stage delay for timing fields; rgb replaced in the last stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1      <= '0;
      r_p2      <= '0;
      r_p3      <= '0;
      r_vblnk_d <= 1'b0;
    end else begin
      r_p1      <= w_in_vec;
      r_p2      <= r_p1;
      r_p3      <= {r_p2[VW-1:12], w_rgb};
      r_vblnk_d <= in.vblnk;
    end
  end

  // Collision accumulator, published and restarted at each vblank start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_collide <= '0;
    end else if (w_latch) begin
      r_collide <= r_acc;
      r_acc     <= w_set;
    end else begin
      r_acc     <= r_acc | w_set;
    end
  end

  assign collide    = r_collide;
  assign out.hcount = r_p3[37:27];
  assign out.vcount = r_p3[26:16];
  assign out.hsync  = r_p3[15];
  assign out.vsync  = r_p3[14];
  assign out.hblnk  = r_p3[13];
  assign out.vblnk  = r_p3[12];
  assign out.rgb    = r_p3[11:0];
endmodule

// File: tb/tb_sprite_layer.sv
// Bench for sprite_layer: directed scenarios plus randomized traffic, all
// checked every cycle against a pixel-level reference model.
module tb_sprite_layer;
  localparam int          N  = 3;
  localparam int          W  = 32;
  localparam int          H  = 32;
  localparam int          AW = 10;
  localparam logic [11:0] TR = 12'hF0F;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*11-1:0] xpos, ypos;
  logic [N-1:0]    spr_en, mirror, collide;
  logic [N*AW-1:0] rom_addr;
  logic [N*12-1:0] rom_data;

  vga_if u_in ();
  vga_if u_out ();

  sprite_layer #(.N_SPR(N), .SPR_W(W), .SPR_H(H), .TRANSP(TR), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in(u_in), .out(u_out),
    .xpos(xpos), .ypos(ypos), .spr_en(spr_en), .mirror(mirror),
    .rom_addr(rom_addr), .rom_data(rom_data), .collide(collide)
  );

  always #5 clk = ~clk;

  // Registered sprite ROMs, one-cycle read latency.
  logic [11:0] rom [N][W*H];
  always @(posedge clk)
    for (int i = 0; i < N; i++) rom_data[i*12 +: 12] <= rom[i][rom_addr[i*AW +: AW]];

  int total = 0, bad = 0, cyc = 0;

  // Reference model state: per-cycle history plus shadow/collision state.
  bit          rst_h [8192];
  logic [37:0] out_h [8192];
  logic [N-1:0] set_h [8192];
  int          sx [N], sy [N];
  bit          sen [N], smir [N];
  bit          m_vbd;
  logic [N-1:0] m_acc, m_col;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // One clock: model the current input pixel, clock, then check outputs.
  task automatic step();
    logic [N*AW-1:0] ea;
    logic [11:0]     prgb;
    logic [N-1:0]    op, st, set;
    logic [37:0]     iv, eo;
    int a [N];
    int h, v, dx, dy, col;
    h  = int'(u_in.hcount);
    v  = int'(u_in.vcount);
    iv = {u_in.hcount, u_in.vcount, u_in.hsync, u_in.vsync, u_in.hblnk, u_in.vblnk, u_in.rgb};
    ea = '0; op = '0; st = '0; prgb = u_in.rgb;
    for (int i = 0; i < N; i++) begin
      a[i] = 0;
      if (!rst && sen[i] && !u_in.hblnk && !u_in.vblnk &&
          h >= sx[i] && h < sx[i] + W && v >= sy[i] && v < sy[i] + H) begin
        dx  = h - sx[i];
        dy  = v - sy[i];
        col = smir[i] ? (W - 1 - dx) : dx;
        a[i] = dy * W + col;
        ea[i*AW +: AW] = AW'(a[i]);
        op[i] = (rom[i][a[i]] != TR);
      end
    end
    for (int i = N-1; i >= 0; i--) if (op[i]) prgb = rom[i][a[i]];
    for (int i = 1; i < N; i++) st[i] = op[0] & op[i];
    rst_h[cyc] = rst;
    out_h[cyc] = {iv[37:12], prgb};
    set_h[cyc] = st;
    if (rst) begin
      for (int i = 0; i < N; i++) begin sx[i] = 0; sy[i] = 0; sen[i] = 0; smir[i] = 0; end
      m_vbd = 0; m_acc = '0; m_col = '0;
    end else begin
      set = '0;
      if (cyc >= 2 && !rst_h[cyc-1] && !rst_h[cyc-2]) set = set_h[cyc-2];
      if (u_in.vblnk && !m_vbd) begin
        m_col = m_acc;
        m_acc = set;
        for (int i = 0; i < N; i++) begin
          sx[i] = int'(xpos[i*11 +: 11]); sy[i] = int'(ypos[i*11 +: 11]);
          sen[i] = spr_en[i]; smir[i] = mirror[i];
        end
      end else begin
        m_acc = m_acc | set;
      end
      m_vbd = u_in.vblnk;
    end
    @(posedge clk);
    @(negedge clk);
    chk("rom_addr", rom_addr, ea);
    chk("collide", collide, m_col);
    if (cyc >= 2) begin
      eo = (rst_h[cyc] || rst_h[cyc-1] || rst_h[cyc-2]) ? 38'd0 : out_h[cyc-2];
      chk("out", {u_out.hcount, u_out.vcount, u_out.hsync, u_out.vsync,
                  u_out.hblnk, u_out.vblnk, u_out.rgb}, eo);
    end
    cyc++;
  endtask

  task automatic drive(input int h, input int v, input bit hb, input bit vb, input logic [11:0] c);
    u_in.hcount = 11'(h); u_in.vcount = 11'(v);
    u_in.hblnk = hb; u_in.vblnk = vb; u_in.hsync = hb; u_in.vsync = vb;
    u_in.rgb = c;
    step();
  endtask

  task automatic pix(input int h, input int v);
    drive(h, v, 1'b0, 1'b0, 12'($urandom));
  endtask

  task automatic idle(input int n);
    repeat (n) drive(300, 600, 1'b1, 1'b0, 12'($urandom));
  endtask

  task automatic vblank();
    repeat (2) drive(0, 700, 1'b1, 1'b1, 12'($urandom));
    idle(1);
  endtask

  task automatic setspr(input int i, input int x, input int y, input bit en, input bit mir);
    xpos[i*11 +: 11] = 11'(x); ypos[i*11 +: 11] = 11'(y);
    spr_en[i] = en; mirror[i] = mir;
  endtask

  initial begin
    for (int i = 0; i < N; i++)
      for (int k = 0; k < W*H; k++)
        rom[i][k] = ($urandom_range(0, 3) == 0) ? TR : 12'($urandom);
    rom[0][67] = 12'h0F0; rom[1][67] = 12'hF00;
    rom[0][95] = 12'h00F; rom[2][64] = 12'h0A0;
    xpos = '0; ypos = '0; spr_en = '0; mirror = '0;
    m_vbd = 0; m_acc = '0; m_col = '0;

    // Reset, then pass-through with every channel disabled.
    rst = 1'b1;
    idle(2);
    chk("rst_collide", collide, 0);
    chk("rst_rgb", u_out.rgb, 0);
    rst = 1'b0;
    for (int k = 0; k < 120; k++)
      drive($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 9) == 0, 1'b0, 12'($urandom));
    vblank();
    for (int k = 0; k < 40; k++) pix($urandom_range(0, 639), $urandom_range(0, 479));

    // Single hit.
    setspr(0, 100, 50, 1'b1, 1'b0);
    vblank();
    pix(103, 52); chk("hit_addr", rom_addr[AW-1:0], 67);
    idle(2);      chk("hit_rgb", u_out.rgb, 12'h0F0);

    // Mirror.
    setspr(0, 100, 50, 1'b1, 1'b1);
    vblank();
    pix(103, 52); chk("mir_addr", rom_addr[AW-1:0], 92);
    pix(131, 52); chk("mir_col0", rom_addr[AW-1:0], 64);
    pix(132, 52); chk("mir_edge", rom_addr[AW-1:0], 0);

    // Priority and transparency.
    setspr(0, 100, 50, 1'b1, 1'b0);
    setspr(1, 100, 50, 1'b1, 1'b0);
    vblank();
    pix(103, 52); idle(2); chk("pri_ch0", u_out.rgb, 12'h0F0);
    idle(1); rom[0][67] = TR;
    pix(103, 52); idle(2); chk("pri_ch1", u_out.rgb, 12'hF00);
    idle(1); rom[1][67] = TR;
    drive(103, 52, 1'b0, 1'b0, 12'h3C5); idle(2); chk("pri_none", u_out.rgb, 12'h3C5);
    idle(1); rom[0][67] = 12'h0F0;

    // Frame latch: mid-frame move is invisible until vblank.
    setspr(1, 0, 0, 1'b0, 1'b0);
    vblank();
    setspr(0, 200, 50, 1'b1, 1'b0);
    pix(103, 52); chk("latch_old", rom_addr[AW-1:0], 67);
    pix(203, 52); chk("latch_hidden", rom_addr[AW-1:0], 0);
    vblank();
    pix(203, 52); chk("latch_new", rom_addr[AW-1:0], 67);
    pix(103, 52); chk("latch_gone", rom_addr[AW-1:0], 0);

    // Collision: ch0 and ch2 overlap at exactly one pixel.
    setspr(0, 100, 50, 1'b1, 1'b0);
    setspr(2, 131, 50, 1'b1, 1'b0);
    vblank();
    for (int h = 95; h <= 170; h++) pix(h, 52);
    idle(3);
    vblank();                 chk("col_set", collide, 3'b100);
    for (int h = 95; h <= 125; h++) pix(h, 52);
    chk("col_hold", collide, 3'b100);
    vblank();                 chk("col_clear", collide, 3'b000);
    pix(131, 52); idle(3);
    vblank();                 chk("col_again", collide, 3'b100);
    pix(110, 60);
    rst = 1'b1; idle(1);      chk("col_rst", collide, 3'b000);
    rst = 1'b0;

    // Randomized traffic, including right/bottom clipping near 2047.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++)
        setspr(i,
               ($urandom_range(0, 4) == 0) ? $urandom_range(2020, 2047) : $urandom_range(0, 90),
               ($urandom_range(0, 4) == 0) ? $urandom_range(2030, 2047) : $urandom_range(0, 40),
               $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      vblank();
      for (int k = 0; k < 60; k++) begin
        if ($urandom_range(0, 29) == 0) xpos[10:0] = 11'($urandom);
        rst = ($urandom_range(0, 249) == 0);
        drive(($urandom_range(0, 7) == 0) ? $urandom_range(2000, 2047) : $urandom_range(0, 130),
              ($urandom_range(0, 7) == 0) ? $urandom_range(2020, 2047) : $urandom_range(0, 75),
              $urandom_range(0, 11) == 0, $urandom_range(0, 24) == 0, 12'($urandom));
      end
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
